// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the
// parity helper, reused by the transmitter and the future receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for a data word zero-extended to 8 bits (zero padding does
  // not change the XOR, so any DBIT in 5..8 can use it).
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity
// bit, stop period. Bit timing comes from an external oversample strobe.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY     = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  // The tick counter must hold the last tick of the longest state.
  localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int BW       = $clog2(DBIT + 1);

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [2:0]      state_r, state_s;
  logic [TW-1:0]   tick_r, tick_s;
  logic [BW-1:0]   bit_r, bit_s;
  logic [DBIT-1:0] shift_r, shift_s;
  logic            par_r, par_s;
  logic            tx_r, tx_s;
  logic            ready_r;
  logic            done_r, done_s;
  logic [7:0]      din_ext_s;

  assign din_ext_s = 8'(din);

  // Next-state logic: counters only move on s_tick, except the IDLE launch.
  always_comb begin
    state_s = state_r;
    tick_s  = tick_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_start) begin
          state_s = ST_START;
          tick_s  = '0;
          bit_s   = '0;
          shift_s = din;
          par_s   = parity_bit(din_ext_s, PARITY);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (tick_r == OS_LAST) begin
            tick_s  = '0;
            state_s = ST_DATA;
          end else begin
            tick_s = tick_r + TICK_ONE;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (tick_r == OS_LAST) begin
            tick_s  = '0;
            shift_s = {1'b0, shift_r[DBIT-1:1]};
            bit_s   = bit_r + BIT_ONE;
            if (bit_r == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                state_s = ST_PAR;
              end else begin
                state_s = ST_STOP;
              end
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            tick_s = tick_r + TICK_ONE;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (tick_r == OS_LAST) begin
            tick_s  = '0;
            state_s = ST_STOP;
          end else begin
            tick_s = tick_r + TICK_ONE;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (tick_r == SB_LAST) begin
            tick_s  = '0;
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            tick_s = tick_r + TICK_ONE;
          end
        end else begin
          tick_s = tick_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the state being entered, so tx can be a plain register.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_IDLE:  tx_s = 1'b1;
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_s[0];
      ST_PAR:   tx_s = par_s;
      ST_STOP:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset leaves the line idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      tick_r  <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tick_r  <= tick_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      ready_r <= (state_s == ST_IDLE);
      done_r  <= done_s;
    end
  end

  assign tx           = tx_r;
  assign tx_ready     = ready_r;
  assign tx_done_tick = done_r;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter DBIT, default 8: number of data bits per frame, legal range 5..8.
- REQ-002 Parameter OVERSAMPLE, default 16: s_tick pulses per start, data or parity bit.
- REQ-003 Parameter SB_TICK, default 16: s_tick pulses per stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- REQ-004 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- REQ-005 clk  input  1  single clock; all state changes on its rising edge.
- REQ-006 reset_n  input  1  reset, asynchronous and active-low.
- REQ-007 s_tick  input  1  one-clk-wide oversample strobe from the upstream baud modcounter "finished" output.
- REQ-008 tx_start  input  1  request to send din; acted on only while tx_ready = 1.
- REQ-009 din  input  DBIT  parallel data word, LSB transmitted first.
- REQ-010 tx_ready  output  1  high only in IDLE; high means a new tx_start is accepted.
- REQ-011 tx_done_tick  output  1  one-clk pulse when the stop period completes.
- REQ-012 tx  output  1  registered serial line; idles high.

Function
- REQ-013 The FSM SHALL have exactly five states: IDLE, START, DATA, PAR, STOP.
- REQ-014 IDLE behaviour:
  - tx = 1 and tx_ready = 1.
  - tx_start = 1 at an edge SHALL load din into the shift register, clear the tick and bit counters, and enter START with tx = 0.
  - The transition is independent of s_tick.
- REQ-015 The tick counter SHALL advance only on clk edges where s_tick = 1; clk edges with s_tick = 0 SHALL hold all state.
- REQ-016 START: on the edge where s_tick = 1 and tick count = OVERSAMPLE-1, the block SHALL clear the tick count, enter DATA and drive tx = shift[0].
- REQ-017 DATA: at each bit end (s_tick = 1, tick count = OVERSAMPLE-1) the block SHALL shift right and increment the bit count.
  - After bit DBIT-1 it SHALL enter PAR if PARITY != 0, otherwise STOP.
  - tx always equals the current shift LSB.
- REQ-018 PAR: tx SHALL be XOR(din) for even parity and its inverse for odd parity, computed from the latched word; the state lasts OVERSAMPLE ticks and then enters STOP.
- REQ-019 STOP: tx = 1 for SB_TICK ticks.
  - On the final tick edge the block SHALL enter IDLE and assert tx_done_tick for that one cycle.
  - tx_ready rises on the same edge.
- REQ-020 Frame length in s_tick pulses SHALL be OVERSAMPLE*(1+DBIT+(PARITY!=0)) + SB_TICK.
- REQ-021 tx_start and din changes outside IDLE SHALL be ignored; the frame in flight is unaffected.
- REQ-022 tx_start held high continuously SHALL produce back-to-back frames, each with a single IDLE cycle between stop end and the next start bit.
- REQ-023 The tick counter width SHALL be clog2 of max(OVERSAMPLE, SB_TICK); the bit counter width SHALL be clog2(DBIT+1); no counter SHALL wrap inside a state.
- REQ-024 tx, tx_ready and tx_done_tick SHALL be driven directly from registers, with no combinational path from any input.

Reset
- REQ-025 Assertion of reset_n = 0 SHALL immediately, without a clock, force:
  - state = IDLE, tx = 1, tx_ready = 1, tx_done_tick = 0;
  - all counters and the shift register = 0.
- REQ-026 Reset mid-frame SHALL abort the frame with no tx_done_tick; the first clk edge after deassertion with tx_start = 1 SHALL begin a fresh frame.

Structure
- REQ-027 A shared package uart_pkg SHALL hold the state encoding constants and the parity codes (PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2), for reuse by the future uart_rx.
- REQ-028 uart_tx SHALL be a single module with no sub-module; the baud tick is supplied externally by a modcounter instance in the parent, e.g. MOD = 326 for 9600 baud x16 at 50 MHz.

Verification
- REQ-029 The bench SHALL cover these directed scenarios:
  - Frame: defaults, s_tick every 4th clk, din = 0xA5, one-cycle tx_start -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held for 64 clk; tx_done_tick pulses once, 640 clk after the start bit.
  - Parity: PARITY = 1, din = 0x07 -> parity bit = 1; PARITY = 2, din = 0x07 -> parity bit = 0; frame = 176 ticks.
  - Busy rejection: tx_start with din = 0x3C pulsed during DATA of a 0x55 frame -> only 0x55 is sent, and no second frame follows.
  - Back-to-back: tx_start held high for two frames (0x00, 0xFF) -> exactly 1 IDLE cycle (tx_ready = 1) between frames, and two tx_done_tick pulses.
  - Reset mid-frame: reset_n = 0 asserted during DATA bit 3 -> tx = 1 within the same cycle, no tx_done_tick; after release, din = 0x81 transmits correctly.
  - Tick gating: s_tick held 0 for 1000 clk in START -> tx stays 0 and the state is unchanged.
